// File: rtl/simple_proc_pkg.sv
// Shared opcodes, FSM state and ALU op-select types for the simple processor core.
package simple_proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_XOR = 2'd2
    } alu_op_e;

    function automatic logic is_alu_op(input logic [3:0] f);
        return (f == OP_ADD) || (f == OP_SUB) || (f == OP_XOR);
    endfunction

endpackage

// File: rtl/simple_proc_alu.sv
// Combinational add/sub/xor unit; carry is ADD carry-out or SUB no-borrow, 0 for XOR.
module simple_proc_alu
    import simple_proc_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_s;

    // Result and carry select; subtraction is a + ~b + 1 so carry means no borrow
    always_comb begin
        sum_s  = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                sum_s  = {1'b0, a} + {1'b0, b};
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            ALU_SUB: begin
                sum_s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            ALU_XOR: begin
                result = a ^ b;
                carry  = 1'b0;
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle bus-based processor: register file, A/G registers, ALU and control FSM.
// Optional zero/carry flag outputs are built when SIMPLE_PROC_FLAGS_EN is defined.
module simple_proc_core
    import simple_proc_pkg::*;
#(
    parameter  int WIDTH  = 3,
    parameter  int NREGS  = 8,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        func,
    input  logic [REG_AW-1:0] rx,
    input  logic [REG_AW-1:0] ry,
    input  logic [WIDTH-1:0]  din,
    output logic              done,
    output logic [WIDTH-1:0]  bus,
    input  logic [REG_AW-1:0] rd_sel,
    output logic [WIDTH-1:0]  rd_data
`ifdef SIMPLE_PROC_FLAGS_EN
    ,
    output logic              zero,
    output logic              carry
`endif
);

    state_e            state_q, state_d;
    logic [3:0]        func_q, func_d;
    logic [REG_AW-1:0] rx_q, rx_d;
    logic [REG_AW-1:0] ry_q, ry_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  g_q, g_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic              done_q, done_d;
    logic [WIDTH-1:0]  bus_s;
    logic [WIDTH-1:0]  alu_result_s;
    logic              alu_carry_s;
    alu_op_e           alu_op_s;

    // Bus source is chosen purely from registered state and captured opcode
    always_comb begin
        bus_s = '0;
        case (state_q)
            T1: begin
                case (func_q)
                    OP_LOAD:                bus_s = din_q;
                    OP_MOV:                 bus_s = regs_q[ry_q];
                    OP_ADD, OP_SUB, OP_XOR: bus_s = regs_q[rx_q];
                    default:                bus_s = '0;
                endcase
            end
            T2:      bus_s = regs_q[ry_q];
            T3:      bus_s = g_q;
            default: bus_s = '0;
        endcase
    end

    // Opcode to ALU operation
    always_comb begin
        case (func_q)
            OP_SUB:  alu_op_s = ALU_SUB;
            OP_XOR:  alu_op_s = ALU_XOR;
            default: alu_op_s = ALU_ADD;
        endcase
    end

    simple_proc_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (bus_s),
        .op     (alu_op_s),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // Control FSM: instruction capture, register/accumulator writes and done generation
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        din_d   = din_q;
        a_d     = a_q;
        g_d     = g_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    func_d  = func;
                    rx_d    = rx;
                    ry_d    = ry;
                    din_d   = din;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            T1: begin
                if (is_alu_op(func_q)) begin
                    a_d     = bus_s;
                    state_d = T2;
                end else begin
                    if ((func_q == OP_LOAD) || (func_q == OP_MOV)) begin
                        regs_d[rx_q] = bus_s;
                    end else begin
                        regs_d = regs_q;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            T2: begin
                g_d     = alu_result_s;
                state_d = T3;
            end
            T3: begin
                regs_d[rx_q] = bus_s;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Core state registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            func_q  <= OP_NOP;
            rx_q    <= '0;
            ry_q    <= '0;
            din_q   <= '0;
            a_q     <= '0;
            g_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            din_q   <= din_d;
            a_q     <= a_d;
            g_q     <= g_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

`ifdef SIMPLE_PROC_FLAGS_EN
    logic zero_q, zero_d;
    logic carry_q, carry_d;

    // Flags follow the ALU only on the result-producing cycle of ALU ops
    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (state_q == T2) begin
            zero_d  = (alu_result_s == '0);
            carry_d = alu_carry_s;
        end else begin
            zero_d  = zero_q;
            carry_d = carry_q;
        end
    end

    // Flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;
`else
    logic unused_carry_s;
    assign unused_carry_s = alu_carry_s;
`endif

    assign instr_ready = (state_q == IDLE);
    assign done        = done_q;
    assign bus         = bus_s;
    assign rd_data     = regs_q[rd_sel];

endmodule

// File: tb/tb_simple_proc_core.sv
// Randomised self-checking bench: WIDTH=3/NREGS=8 and WIDTH=8/NREGS=16 cores run in lockstep
// against an instruction-level reference model.
module tb_simple_proc_core;
    import simple_proc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] func;
    logic [3:0] rx, ry, rd_sel;
    logic [7:0] din;

    logic       ready3, done3, ready8, done8;
    logic [2:0] bus3, rd3;
    logic [7:0] bus8, rd8;
`ifdef SIMPLE_PROC_FLAGS_EN
    logic       zero3, carry3, zero8, carry8;
`endif

    int checks = 0;
    int errors = 0;
    int mr [2][16];
    int mz [2];
    int mc [2];
    int wd [2] = '{3, 8};
    int am [2] = '{7, 15};

    always #50 clk = ~clk;

    simple_proc_core #(.WIDTH(3), .NREGS(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ready3),
        .func(func), .rx(rx[2:0]), .ry(ry[2:0]), .din(din[2:0]), .done(done3),
        .bus(bus3), .rd_sel(rd_sel[2:0]), .rd_data(rd3)
`ifdef SIMPLE_PROC_FLAGS_EN
        , .zero(zero3), .carry(carry3)
`endif
    );

    simple_proc_core #(.WIDTH(8), .NREGS(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ready8),
        .func(func), .rx(rx), .ry(ry), .din(din), .done(done8),
        .bus(bus8), .rd_sel(rd_sel), .rd_data(rd8)
`ifdef SIMPLE_PROC_FLAGS_EN
        , .zero(zero8), .carry(carry8)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mr[k][i] = 0;
            mz[k] = 0;
            mc[k] = 0;
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            rd_sel = 4'(i);
            #1;
            if (i < 8) check_eq($sformatf("rd3[%0d]", i), 32'(rd3), 32'(mr[0][i]));
            check_eq($sformatf("rd8[%0d]", i), 32'(rd8), 32'(mr[1][i]));
        end
    endtask

    task automatic check_flags();
`ifdef SIMPLE_PROC_FLAGS_EN
        check_eq("zero3", 32'(zero3), 32'(mz[0]));
        check_eq("carry3", 32'(carry3), 32'(mc[0]));
        check_eq("zero8", 32'(zero8), 32'(mz[1]));
        check_eq("carry8", 32'(carry8), 32'(mc[1]));
`endif
    endtask

    // Issue one instruction from the low phase of an idle cycle; returns in the done cycle.
    task automatic run_instr(input logic [3:0] f, input int x, input int y, input int d);
        int  lat, mask, xi, yi, xv, yv, dv, res, c;
        int  be [2][5];
        int  wres [2];
        int  wc [2];
        bit  alu, wr;
        alu = (f == OP_ADD) || (f == OP_SUB) || (f == OP_XOR);
        wr  = alu || (f == OP_LOAD) || (f == OP_MOV);
        lat = alu ? 4 : 2;
        for (int k = 0; k < 2; k++) begin
            mask = (1 << wd[k]) - 1;
            xi = x & am[k];
            yi = y & am[k];
            xv = mr[k][xi];
            yv = mr[k][yi];
            dv = d & mask;
            res = 0;
            c = 0;
            for (int n = 0; n < 5; n++) be[k][n] = 0;
            case (f)
                OP_LOAD: begin res = dv; be[k][1] = dv; end
                OP_MOV:  begin res = yv; be[k][1] = yv; end
                OP_ADD:  begin res = (xv + yv) & mask; c = ((xv + yv) >> wd[k]) & 1; end
                OP_SUB:  begin res = (xv - yv) & mask; c = (xv >= yv) ? 1 : 0; end
                OP_XOR:  begin res = xv ^ yv; c = 0; end
                default: res = 0;
            endcase
            if (alu) begin
                be[k][1] = xv;
                be[k][2] = yv;
                be[k][3] = res;
            end
            wres[k] = res;
            wc[k]   = c;
        end
        func = f; rx = 4'(x); ry = 4'(y); din = 8'(d);
        instr_valid = 1'b1;
        #1;
        check_eq("ready3_issue", 32'(ready3), 32'd1);
        check_eq("ready8_issue", 32'(ready8), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        func = 4'($urandom); rx = 4'($urandom); ry = 4'($urandom); din = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            if (wr) mr[k][x & am[k]] = wres[k];
            if (alu) begin
                mz[k] = (wres[k] == 0) ? 1 : 0;
                mc[k] = wc[k];
            end
        end
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            check_eq("done3", 32'(done3), (n == lat) ? 32'd1 : 32'd0);
            check_eq("done8", 32'(done8), (n == lat) ? 32'd1 : 32'd0);
            check_eq("ready3", 32'(ready3), (n == lat) ? 32'd1 : 32'd0);
            check_eq("ready8", 32'(ready8), (n == lat) ? 32'd1 : 32'd0);
            check_eq($sformatf("bus3_c%0d", n), 32'(bus3), 32'(be[0][n]));
            check_eq($sformatf("bus8_c%0d", n), 32'(bus8), 32'(be[1][n]));
            if (alu && n == 2) begin
                instr_valid = 1'b1;
                func = OP_LOAD; rx = 4'($urandom); din = 8'($urandom);
            end
            if (alu && n == 3) instr_valid = 1'b0;
        end
        check_regs();
        check_flags();
    endtask

    task automatic reset_mid_add();
        func = OP_ADD; rx = 4'($urandom); ry = 4'($urandom);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_done3", 32'(done3), 32'd0);
        check_eq("rst_bus8", 32'(bus8), 32'd0);
        check_eq("rst_ready8", 32'(ready8), 32'd1);
        check_regs();
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_eq("post_rst_done3", 32'(done3), 32'd0);
            check_eq("post_rst_done8", 32'(done8), 32'd0);
            check_eq("post_rst_ready3", 32'(ready3), 32'd1);
        end
    endtask

    task automatic random_block(input int count);
        logic [3:0] f;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 9) < 7) f = 4'($urandom_range(1, 5));
            else f = 4'($urandom_range(0, 15));
            run_instr(f, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check_eq("idle_done8", 32'(done8), 32'd0);
                check_eq("idle_bus3", 32'(bus3), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        func = 4'd0; rx = 4'd0; ry = 4'd0; din = 8'd0; rd_sel = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_ready3", 32'(ready3), 32'd1);
        check_eq("reset_done8", 32'(done8), 32'd0);
        check_eq("reset_bus3", 32'(bus3), 32'd0);
        check_regs();
        check_flags();
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(OP_LOAD, 4, 0, 3);
        run_instr(OP_LOAD, 5, 0, 5);
        run_instr(OP_ADD, 4, 5, 0);
        rd_sel = 4'd4;
        #1;
        check_eq("add_wrap_r4", 32'(rd3), 32'd0);
        run_instr(OP_LOAD, 4, 0, 5);
        run_instr(OP_LOAD, 5, 0, 3);
        run_instr(OP_SUB, 4, 5, 0);
        run_instr(OP_SUB, 5, 4, 0);
        run_instr(OP_XOR, 4, 4, 0);
        run_instr(OP_MOV, 7, 5, 0);
        run_instr(4'b1111, 2, 3, 7);
        run_instr(OP_LOAD, 1, 0, 200);
        run_instr(OP_LOAD, 2, 0, 100);
        run_instr(OP_ADD, 1, 2, 0);
        rd_sel = 4'd1;
        #1;
        check_eq("add8_200_100", 32'(rd8), 32'd44);
        run_instr(OP_ADD, 3, 3, 0);
        run_instr(OP_SUB, 3, 3, 0);

        random_block(150);
        @(negedge clk);
        reset_mid_add();
        random_block(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
